// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_ripple_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to index 0..value-1; never less than one.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor slice: d = x - y - bin, with borrow out.
module full_subtractor
  import serial_ripple_subtractor_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock via a single slice.
// Define SERIAL_SUB_OVF_EN to enable the signed overflow flag on ovf.
module serial_ripple_subtractor
  import serial_ripple_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    count;
  logic             br;
  logic             d_bit;
  logic             bo_bit;
  logic [WIDTH-1:0] shifted;

  full_subtractor u_slice (
    .x   (a_reg[count]),
    .y   (b_reg[count]),
    .bin (br),
    .d   (d_bit),
    .bo  (bo_bit)
  );

  // New bits enter at the MSB, so after WIDTH shifts bit 0 lands in position 0.
  assign shifted = {d_bit, shift_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      shift_reg <= '0;
      count     <= '0;
      br        <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            shift_reg <= '0;
            count     <= '0;
            br        <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          shift_reg <= shifted;
          br        <= bo_bit;
          count     <= count + CW'(1);
          // Visible outputs change only here, so partial results never leak out.
          if (count == LAST) begin
            diff  <= shifted;
            bout  <= bo_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &
                     (shifted[WIDTH-1] != a_reg[WIDTH-1]);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed self-checking bench for serial_ripple_subtractor (WIDTH = 4).
module tb_serial_ripple_subtractor;

  localparam int WIDTH = 4;

`ifdef SERIAL_SUB_OVF_EN
  localparam logic OVF_8_MINUS_1 = 1'b1;
`else
  localparam logic OVF_8_MINUS_1 = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;
  logic             ovf;

  int compared   = 0;
  int mismatched = 0;

  serial_ripple_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue a one-cycle start at the next edge; returns at edge+1.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Waits (bounded) for done; busy must stay high until it arrives.
  task automatic waitDone(input string tag, output int cycles);
    cycles = 0;
    while (!done && cycles < 12) begin
      @(posedge clk);
      #1;
      cycles++;
      if (!done) checkOutput({tag, "_busy_run"}, 32'(busy), 32'd1);
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(WIDTH));
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [WIDTH-1:0] exp_diff, input logic exp_bout, input logic exp_ovf);
    int cycles;
    applyStimulus(av, bv);
    waitDone(tag, cycles);
    checkOutput({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    checkOutput({tag, "_bout"}, 32'(bout), 32'(exp_bout));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cycles;
    int done_count;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    checkOutput("reset_diff", 32'(diff), 32'd0);
    checkOutput("reset_bout", 32'(bout), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runOp("5m3", 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0);
    runOp("3m5", 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0);

    // Asynchronous reset between edges must clear outputs without a clock.
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_diff", 32'(diff), 32'd0);
    checkOutput("async_rst_bout", 32'(bout), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_done", 32'(done), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runOp("FmF", 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
    runOp("0m1", 4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0);
    runOp("8m1", 4'b1000, 4'b0001, 4'b0111, 1'b0, OVF_8_MINUS_1);
    runOp("5m3_ovf", 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0);

    // Start held high with operands changing mid-run.
    a     = 4'b0011;
    b     = 4'b0101;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 4'b1111;
    b = 4'b0000;
    done_count = 0;
    cycles = 0;
    while (!done && cycles < 12) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (done) done_count++;
    checkOutput("hold_latency", 32'(cycles), 32'(WIDTH));
    checkOutput("hold_diff", 32'(diff), 32'h0000000E);
    checkOutput("hold_bout", 32'(bout), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("hold_done_clear", 32'(done), 32'd0);
    checkOutput("hold_idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("hold_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    waitDone("hold2", cycles);
    done_count++;
    checkOutput("hold2_diff", 32'(diff), 32'h0000000F);
    checkOutput("hold2_bout", 32'(bout), 32'd0);
    checkOutput("hold_done_count", 32'(done_count), 32'd2);
    @(posedge clk);
    #1;

    // Reset at count = 2 discards the run; no done afterwards.
    applyStimulus(4'b0110, 4'b0001);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    done_count = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) done_count++;
    end
    checkOutput("midrst_no_done", 32'(done_count), 32'd0);
    checkOutput("midrst_diff", 32'(diff), 32'd0);
    checkOutput("midrst_bout", 32'(bout), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    runOp("after_rst_5m3", 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
